// File: rtl/xrv_pkg.sv
// Shared types and constants for the xrv instruction-memory slice.
package xrv_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_HDR,
    LD_DATA,
    LD_DONE
  } ld_state_t;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/xrv_sram_1r1w.sv
// Single-read single-write synchronous SRAM; registered read, read-first on address collision.
module xrv_sram_1r1w #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/xrv_imem.sv
// Instruction memory with 1-cycle fetch port and a byte-stream program loader
// that holds the core in reset while loading.
module xrv_imem
  import xrv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] OOR_WORD    = RV_NOP,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  output logic [31:0] i_data,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_ready,
  output logic        cpu_hold,
  output logic        ld_done,
  output logic        ld_err
);

  ld_state_t   state;
  logic [1:0]  byte_cnt;
  logic [31:0] wcount;
  logic [31:0] word_idx;
  logic [23:0] word_buf;
  logic        oor_q;
  logic [31:0] rdata;

  logic        accept;
  logic        in_range;
  logic        we;
  logic [31:0] hdr_word;
  logic [31:0] full_word;
  logic        unused_addr_bits;

  assign accept           = ld_valid & ld_ready;
  assign in_range         = (i_addr[31:AW+2] == '0);
  assign hdr_word         = {ld_byte, wcount[31:8]};
  assign full_word        = {ld_byte, word_buf};
  assign we               = (state == LD_DATA) && accept && (byte_cnt == 2'd3) &&
                            (word_idx < 32'(DEPTH_WORDS));
  assign unused_addr_bits = ^i_addr[1:0];

  xrv_sram_1r1w #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (32)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (word_idx[AW-1:0]),
    .wdata (full_word),
    .raddr (i_addr[AW+1:2]),
    .rdata (rdata)
  );

  // Range decision is registered alongside the array read so the mux lines up.
  always_ff @(posedge clk) begin
    if (rst) oor_q <= 1'b0;
    else     oor_q <= ~in_range;
  end

  assign i_data = oor_q ? OOR_WORD : rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_IDLE;
      ld_ready <= 1'b0;
      cpu_hold <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      byte_cnt <= '0;
      wcount   <= '0;
      word_idx <= '0;
      word_buf <= '0;
    end else begin
      case (state)
        LD_IDLE: begin
          if (ld_start) begin
            state    <= LD_HDR;
            ld_ready <= 1'b1;
            cpu_hold <= 1'b1;
            ld_err   <= 1'b0;
            byte_cnt <= '0;
            wcount   <= '0;
            word_idx <= '0;
          end
        end
        LD_HDR: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            wcount   <= hdr_word;
            if (byte_cnt == 2'd3) begin
              if (hdr_word == '0) begin
                state    <= LD_DONE;
                ld_ready <= 1'b0;
                ld_done  <= 1'b1;
              end else begin
                state <= LD_DATA;
              end
            end
          end
        end
        LD_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_buf <= {ld_byte, word_buf[23:8]};
            if (byte_cnt == 2'd3) begin
              word_idx <= word_idx + 32'd1;
              if (word_idx >= 32'(DEPTH_WORDS)) ld_err <= 1'b1;
              if (word_idx == wcount - 32'd1) begin
                state    <= LD_DONE;
                ld_ready <= 1'b0;
                ld_done  <= 1'b1;
              end
            end
          end
        end
        LD_DONE: begin
          state    <= LD_IDLE;
          ld_done  <= 1'b0;
          cpu_hold <= 1'b0;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
